// File: rtl/round_timer_ctrl.sv
// Phase timer scheduler for the game-state controller: turns the per-frame tick
// into the Ready/DiveKick/Playing/Pause2 timers and keeps the round counter.
module round_timer_ctrl #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int ROUND_SECONDS  = 9
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [3:0] gameState,
  output logic [3:0] gameTime,
  output logic [1:0] readyTime,
  output logic [1:0] DiveKickTime,
  output logic [1:0] pauseTime,
  output logic [3:0] round_num
);

  localparam int CW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [CW-1:0] LIM_FULL = CW'(FRAMES_PER_SEC - 1);
  localparam logic [CW-1:0] LIM_HALF = CW'(FRAMES_PER_SEC / 2 - 1);
  localparam logic [3:0] ROUND_INIT = 4'(ROUND_SECONDS);

  localparam logic [3:0] S_TITLE  = 4'd0;
  localparam logic [3:0] S_PLAY   = 4'd3;
  localparam logic [3:0] S_PAUSE2 = 4'd6;
  localparam logic [3:0] S_READY  = 4'd8;
  localparam logic [3:0] S_DIVE   = 4'd9;

  logic [3:0]    r_prev_state;
  logic [CW-1:0] r_frame_cnt;

  logic          w_entry;
  logic          w_timed;
  logic [CW-1:0] w_limit;
  logic          w_period;

  always_comb begin
    w_entry  = (gameState != r_prev_state);
    w_timed  = (gameState == S_PLAY) || (gameState == S_PAUSE2) ||
               (gameState == S_READY) || (gameState == S_DIVE);
    w_limit  = (gameState == S_DIVE) ? LIM_HALF : LIM_FULL;
    // An entry on a tick cycle swallows the tick.
    w_period = w_timed && !w_entry && frame_tick && (r_frame_cnt == w_limit);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_prev_state <= S_TITLE;
      r_frame_cnt  <= '0;
    end else begin
      r_prev_state <= gameState;
      if (w_entry || !w_timed)
        r_frame_cnt <= '0;
      else if (frame_tick)
        r_frame_cnt <= w_period ? '0 : r_frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      readyTime    <= 2'd0;
      DiveKickTime <= 2'd0;
      pauseTime    <= 2'd0;
    end else begin
      if (gameState != S_READY)
        readyTime <= 2'd0;
      else if (w_period && readyTime != 2'd3)
        readyTime <= readyTime + 2'd1;

      if (gameState != S_DIVE)
        DiveKickTime <= 2'd0;
      else if (w_period && DiveKickTime != 2'd3)
        DiveKickTime <= DiveKickTime + 2'd1;

      if (gameState != S_PAUSE2)
        pauseTime <= 2'd0;
      else if (w_period && pauseTime != 2'd3)
        pauseTime <= pauseTime + 2'd1;
    end
  end

  // gameTime holds outside Playing so the final time stays on screen.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      gameTime  <= ROUND_INIT;
      round_num <= 4'd0;
    end else begin
      if (gameState == S_TITLE || (gameState == S_READY && w_entry))
        gameTime <= ROUND_INIT;
      else if (gameState == S_PLAY && w_period && gameTime != 4'd0)
        gameTime <= gameTime - 4'd1;

      if (gameState == S_TITLE)
        round_num <= 4'd0;
      else if (gameState == S_READY && w_entry && round_num != 4'd15)
        round_num <= round_num + 4'd1;
    end
  end

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Scoreboard bench for round_timer_ctrl with FRAMES_PER_SEC=4, ROUND_SECONDS=9.
module tb_round_timer_ctrl;

  localparam int FPS = 4;
  localparam int RS  = 9;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [3:0] gameState = 4'd0;
  logic [3:0] gameTime;
  logic [1:0] readyTime;
  logic [1:0] DiveKickTime;
  logic [1:0] pauseTime;
  logic [3:0] round_num;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] e;

  round_timer_ctrl #(.FRAMES_PER_SEC(FPS), .ROUND_SECONDS(RS)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .gameState(gameState),
    .gameTime(gameTime), .readyTime(readyTime), .DiveKickTime(DiveKickTime),
    .pauseTime(pauseTime), .round_num(round_num)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  function automatic int sat3(int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    gameState = 4'($urandom_range(0, 15));
    frame_tick = 1'b1;
    exp_q.push_back(4'(RS));
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
    step();
    step();
    e = exp_q.pop_front(); n_checks++;
    if (gameTime !== e) $display("FAIL reset_gameTime: got %0d want %0d", gameTime, e); else n_pass++;
    e = exp_q.pop_front(); n_checks++;
    if ({2'b0, readyTime} !== e) $display("FAIL reset_readyTime: got %0d want %0d", readyTime, e); else n_pass++;
    e = exp_q.pop_front(); n_checks++;
    if ({2'b0, DiveKickTime} !== e) $display("FAIL reset_DiveKickTime: got %0d want %0d", DiveKickTime, e); else n_pass++;
    e = exp_q.pop_front(); n_checks++;
    if ({2'b0, pauseTime} !== e) $display("FAIL reset_pauseTime: got %0d want %0d", pauseTime, e); else n_pass++;
    e = exp_q.pop_front(); n_checks++;
    if (round_num !== e) $display("FAIL reset_round_num: got %0d want %0d", round_num, e); else n_pass++;
    frame_tick = 1'b0;
    gameState = 4'd0;
    Reset = 1'b0;
    step();
  endtask

  task automatic test_ready();
    gameState = 4'd8;
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd0);
    step();
    e = exp_q.pop_front(); n_checks++;
    if (round_num !== e) $display("FAIL ready_round_num: got %0d want %0d", round_num, e); else n_pass++;
    e = exp_q.pop_front(); n_checks++;
    if ({2'b0, readyTime} !== e) $display("FAIL ready_first_cycle: got %0d want %0d", readyTime, e); else n_pass++;
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(4'(sat3(i / FPS)));
      tick();
      e = exp_q.pop_front(); n_checks++;
      if ({2'b0, readyTime} !== e) $display("FAIL ready_tick%0d: got %0d want %0d", i, readyTime, e); else n_pass++;
      step();
      step();
    end
  endtask

  task automatic test_divekick();
    gameState = 4'd9;
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
    step();
    e = exp_q.pop_front(); n_checks++;
    if ({2'b0, readyTime} !== e) $display("FAIL dive_ready_cleared: got %0d want %0d", readyTime, e); else n_pass++;
    e = exp_q.pop_front(); n_checks++;
    if ({2'b0, DiveKickTime} !== e) $display("FAIL dive_entry: got %0d want %0d", DiveKickTime, e); else n_pass++;
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back(4'(sat3(i / (FPS / 2))));
      tick();
      e = exp_q.pop_front(); n_checks++;
      if ({2'b0, DiveKickTime} !== e) $display("FAIL dive_tick%0d: got %0d want %0d", i, DiveKickTime, e); else n_pass++;
      step();
    end
  endtask

  task automatic test_playing();
    int g;
    gameState = 4'd3;
    exp_q.push_back(4'(RS));
    step();
    e = exp_q.pop_front(); n_checks++;
    if (gameTime !== e) $display("FAIL play_first_cycle: got %0d want %0d", gameTime, e); else n_pass++;
    for (int i = 1; i <= RS * FPS + 8; i++) begin
      g = RS - i / FPS;
      exp_q.push_back(4'((g < 0) ? 0 : g));
      tick();
      e = exp_q.pop_front(); n_checks++;
      if (gameTime !== e) $display("FAIL play_tick%0d: got %0d want %0d", i, gameTime, e); else n_pass++;
      step();
    end
    gameState = 4'd4;
    exp_q.push_back(4'd0);
    tick();
    e = exp_q.pop_front(); n_checks++;
    if (gameTime !== e) $display("FAIL pause_hold: got %0d want %0d", gameTime, e); else n_pass++;
    gameState = 4'd5;
    exp_q.push_back(4'd0);
    tick();
    step();
    e = exp_q.pop_front(); n_checks++;
    if (gameTime !== e) $display("FAIL reset_state_hold: got %0d want %0d", gameTime, e); else n_pass++;
  endtask

  task automatic test_entry_tick();
    gameState = 4'd8;
    exp_q.push_back(4'd2);
    exp_q.push_back(4'(RS));
    step();
    e = exp_q.pop_front(); n_checks++;
    if (round_num !== e) $display("FAIL second_round_num: got %0d want %0d", round_num, e); else n_pass++;
    e = exp_q.pop_front(); n_checks++;
    if (gameTime !== e) $display("FAIL ready_reload: got %0d want %0d", gameTime, e); else n_pass++;
    tick();
    step();
    gameState = 4'd9;
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
    tick();
    e = exp_q.pop_front(); n_checks++;
    if ({{(4-$bits(dut.r_frame_cnt)){1'b0}}, dut.r_frame_cnt} !== e)
      $display("FAIL entry_tick_frame_cnt: got %0d want %0d", dut.r_frame_cnt, e); else n_pass++;
    e = exp_q.pop_front(); n_checks++;
    if ({2'b0, DiveKickTime} !== e) $display("FAIL entry_tick_dive: got %0d want %0d", DiveKickTime, e); else n_pass++;
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back(4'(i / 2));
      tick();
      e = exp_q.pop_front(); n_checks++;
      if ({2'b0, DiveKickTime} !== e) $display("FAIL entry_tick_after%0d: got %0d want %0d", i, DiveKickTime, e); else n_pass++;
      step();
    end
  endtask

  task automatic test_pause2_reset();
    gameState = 4'd6;
    step();
    for (int i = 1; i <= 2 * FPS; i++) begin
      exp_q.push_back(4'(sat3(i / FPS)));
      tick();
      e = exp_q.pop_front(); n_checks++;
      if ({2'b0, pauseTime} !== e) $display("FAIL pause2_tick%0d: got %0d want %0d", i, pauseTime, e); else n_pass++;
      step();
    end
    tick();
    Reset = 1'b1;
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'(RS));
    step();
    Reset = 1'b0;
    e = exp_q.pop_front(); n_checks++;
    if ({2'b0, pauseTime} !== e) $display("FAIL midreset_pauseTime: got %0d want %0d", pauseTime, e); else n_pass++;
    e = exp_q.pop_front(); n_checks++;
    if (round_num !== e) $display("FAIL midreset_round_num: got %0d want %0d", round_num, e); else n_pass++;
    e = exp_q.pop_front(); n_checks++;
    if (gameTime !== e) $display("FAIL midreset_gameTime: got %0d want %0d", gameTime, e); else n_pass++;
    gameState = 4'd8;
    exp_q.push_back(4'd1);
    step();
    e = exp_q.pop_front(); n_checks++;
    if (round_num !== e) $display("FAIL reentry_round_num: got %0d want %0d", round_num, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ready();
    test_divekick();
    test_playing();
    test_entry_tick();
    test_pause2_reset();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
